// File: rtl/pixel_array_sequencer_pkg.sv
// Shared pixel-sensor configuration: frame states, default geometry/timing,
// and a small index-width helper used for row/column ports.
package pixel_array_sequencer_pkg;

  localparam int DEF_HEIGHT        = 2;
  localparam int DEF_WIDTH         = 2;
  localparam int DEF_BITS          = 8;
  localparam int DEF_ERASE_CYCLES  = 5;
  localparam int DEF_EXPOSE_CYCLES = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_SELECT,
    S_CAPTURE,
    S_STREAM,
    S_DONE
  } seq_state_e;

  typedef logic [DEF_BITS-1:0] pix_word_t;

  // Index width for n entries; a single entry still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// One-row line buffer: captures all WIDTH words of the array bus on
// cap_en_i and serves one word at a time through a column mux.
module pixel_line_buffer
  import pixel_array_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BITS  = DEF_BITS,
  parameter int CW    = idx_w(DEF_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cap_en_i,
  input  logic [WIDTH*BITS-1:0] data_i,
  input  logic [CW-1:0]         col_i,
  output logic [BITS-1:0]       pix_o
);

  logic [WIDTH-1:0][BITS-1:0] buf_q;

  // Whole-row capture; the bus is ignored whenever capture is not enabled.
  always_ff @(posedge clk_i) begin
    if (reset_i)       buf_q <= '0;
    else if (cap_en_i) buf_q <= data_i;
  end

  assign pix_o = buf_q[col_i];

endmodule

// File: rtl/pixel_array_sequencer.sv
// Frame controller beside the pixel array: erase, expose, ramp conversion,
// then row-by-row capture into a line buffer and valid/ready pixel streaming.
module pixel_array_sequencer
  import pixel_array_sequencer_pkg::*;
#(
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int BITS          = DEF_BITS,
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     ERASE,
  output logic                     EXPOSE,
  output logic                     ANALOG_RAMP,
  output logic [BITS-1:0]          DIGITAL_RAMP,
  output logic [HEIGHT-1:0]        READ,
  input  logic [WIDTH*BITS-1:0]    ARRAY_DATA,
  output logic [BITS-1:0]          PIX_DATA,
  output logic [idx_w(HEIGHT)-1:0] PIX_ROW,
  output logic [idx_w(WIDTH)-1:0]  PIX_COL,
  output logic                     PIX_VALID,
  input  logic                     PIX_READY,
  output logic                     PIX_LAST,
  output logic                     FRAME_DONE
);

  localparam int RW   = idx_w(HEIGHT);
  localparam int CW   = idx_w(WIDTH);
  localparam int PMAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  seq_state_e      state_q;
  logic [PW-1:0]   cnt_q;    // erase/expose phase length
  logic [BITS-1:0] ramp_q;   // conversion ramp value
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [BITS-1:0] buf_pix;

  logic row_last, col_last;
  assign row_last = (row_q == RW'(HEIGHT - 1));
  assign col_last = (col_q == CW'(WIDTH - 1));

  // Frame state machine with its phase, ramp, row and column counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ramp_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (START) state_q <= S_ERASE;
        end
        S_ERASE: begin
          if (cnt_q == PW'(ERASE_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_EXPOSE;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        S_EXPOSE: begin
          if (cnt_q == PW'(EXPOSE_CYCLES - 1)) begin
            cnt_q   <= '0;
            ramp_q  <= '0;
            state_q <= S_CONVERT;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        S_CONVERT: begin
          if (ramp_q == '1) begin
            ramp_q  <= '0;
            row_q   <= '0;
            state_q <= S_SELECT;
          end else begin
            ramp_q <= ramp_q + BITS'(1);
          end
        end
        S_SELECT:  state_q <= S_CAPTURE;
        S_CAPTURE: begin
          col_q   <= '0;
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (PIX_READY) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                state_q <= S_DONE;
              end else begin
                row_q   <= row_q + RW'(1);
                state_q <= S_SELECT;
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          row_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One-hot row select while the selected row settles and is captured.
  always_comb begin
    READ = '0;
    if (state_q == S_SELECT || state_q == S_CAPTURE)
      for (int i = 0; i < HEIGHT; i++) READ[i] = (row_q == RW'(i));
  end

  pixel_line_buffer #(
    .WIDTH (WIDTH),
    .BITS  (BITS),
    .CW    (CW)
  ) u_line_buf (
    .clk_i    (clk),
    .reset_i  (reset),
    .cap_en_i (state_q == S_CAPTURE),
    .data_i   (ARRAY_DATA),
    .col_i    (col_q),
    .pix_o    (buf_pix)
  );

  // Outputs decode directly from registered state, so they are glitch-free
  // and cannot react combinationally to PIX_READY.
  assign BUSY         = (state_q != S_IDLE);
  assign ERASE        = (state_q == S_ERASE);
  assign EXPOSE       = (state_q == S_EXPOSE);
  assign ANALOG_RAMP  = (state_q == S_CONVERT);
  assign DIGITAL_RAMP = ANALOG_RAMP ? ramp_q : '0;
  assign PIX_VALID    = (state_q == S_STREAM);
  assign PIX_DATA     = PIX_VALID ? buf_pix : '0;
  assign PIX_ROW      = PIX_VALID ? row_q : '0;
  assign PIX_COL      = PIX_VALID ? col_q : '0;
  assign PIX_LAST     = PIX_VALID && row_last && col_last;
  assign FRAME_DONE   = (state_q == S_DONE);

endmodule
